// File: rtl/ctrl_pkg.sv
// ctrl_pkg -- shared definitions for the control sequencer.
// Holds the FSM state encoding, ALU operation codes, write-back select
// codes, the bit positions of the one-hot decoded instruction flags,
// and a one-hot test helper used by the decode step.
package ctrl_pkg;

  localparam int IFLAGS_W = 16;

  typedef enum logic [2:0] {
    ST_FETCH   = 3'd0,
    ST_LOAD_IR = 3'd1,
    ST_DECODE  = 3'd2,
    ST_EXEC    = 3'd3,
    ST_MEM     = 3'd4,
    ST_HALT    = 3'd5
  } state_e;

  localparam logic [2:0] ALU_PASS = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;
  localparam logic [2:0] ALU_AND  = 3'd3;
  localparam logic [2:0] ALU_NOT  = 3'd4;
  localparam logic [2:0] ALU_SHR  = 3'd5;
  localparam logic [2:0] ALU_SHL  = 3'd6;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_IN  = 2'd2;

  localparam int IF_MOVA = 15;
  localparam int IF_MOVB = 14;
  localparam int IF_MOVC = 13;
  localparam int IF_ADD  = 12;
  localparam int IF_SUB  = 11;
  localparam int IF_AND1 = 10;
  localparam int IF_NOT1 = 9;
  localparam int IF_RSR  = 8;
  localparam int IF_RSL  = 7;
  localparam int IF_JMP  = 6;
  localparam int IF_JZ   = 5;
  localparam int IF_JC   = 4;
  localparam int IF_IN1  = 3;
  localparam int IF_OUT1 = 2;
  localparam int IF_NOP  = 1;
  localparam int IF_HALT = 0;

  // True when exactly one bit is set: non-zero and clearing the lowest
  // set bit leaves nothing.
  function automatic logic is_one_hot(input logic [IFLAGS_W-1:0] v);
    return (v != '0) && ((v & (v - IFLAGS_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/ctrl_sequencer_if.sv
// ctrl_sequencer_if -- bundles the sequencer's datapath-facing signals.
//   Inputs to the sequencer : run, iflags[15:0], alu_z, alu_c
//   Strobes from sequencer  : dec_en, mem_rd, mem_wr, addr_sel, ir_ld,
//                             pc_inc, pc_ld, reg_we, wb_sel[1:0],
//                             alu_op[2:0], in_en, out_en
//   Status from sequencer   : halted, illegal, state[2:0]
// master = the sequencer itself, slave = the datapath/environment.
interface ctrl_sequencer_if;
  import ctrl_pkg::*;

  logic                run;
  logic [IFLAGS_W-1:0] iflags;
  logic                alu_z;
  logic                alu_c;

  logic                dec_en;
  logic                mem_rd;
  logic                mem_wr;
  logic                addr_sel;
  logic                ir_ld;
  logic                pc_inc;
  logic                pc_ld;
  logic                reg_we;
  logic [1:0]          wb_sel;
  logic [2:0]          alu_op;
  logic                in_en;
  logic                out_en;
  logic                halted;
  logic                illegal;
  logic [2:0]          state;

  modport master (
    input  run, iflags, alu_z, alu_c,
    output dec_en, mem_rd, mem_wr, addr_sel, ir_ld, pc_inc, pc_ld,
           reg_we, wb_sel, alu_op, in_en, out_en, halted, illegal, state
  );

  modport slave (
    output run, iflags, alu_z, alu_c,
    input  dec_en, mem_rd, mem_wr, addr_sel, ir_ld, pc_inc, pc_ld,
           reg_we, wb_sel, alu_op, in_en, out_en, halted, illegal, state
  );

endinterface

// File: rtl/ctrl_sequencer_flag_reg.sv
// flag_reg -- zero/carry flag holding register.
//   clk, rst : clock and asynchronous active-high clear
//   ld       : capture z_in/c_in on the next rising edge
//   z_in/c_in: combinational ALU zero/carry results
//   zf/cf    : held flags
module flag_reg (
  input  logic clk,
  input  logic rst,
  input  logic ld,
  input  logic z_in,
  input  logic c_in,
  output logic zf,
  output logic cf
);

  logic zf_q, zf_d;
  logic cf_q, cf_d;

  always_comb begin
    zf_d = zf_q;
    cf_d = cf_q;
    if (ld) begin
      zf_d = z_in;
      cf_d = c_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zf_q <= 1'b0;
      cf_q <= 1'b0;
    end else begin
      zf_q <= zf_d;
      cf_q <= cf_d;
    end
  end

  assign zf = zf_q;
  assign cf = cf_q;

endmodule

// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer -- multi-cycle control FSM for a small accumulator CPU.
//   clk : rising-edge system clock
//   rst : asynchronous active-high reset
//   bus : ctrl_sequencer_if.master -- run/iflags/ALU flags in, strobes and
//         status (halted, illegal, state) out
// Instruction flow: FETCH -> LOAD_IR -> DECODE -> EXEC [-> MEM] -> FETCH.
// Strobes depend only on the current state and the latched instruction
// (plus run in FETCH and the one-hot check of iflags in DECODE).
module ctrl_sequencer
  import ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  ctrl_sequencer_if.master bus
);

  state_e              state_q, state_d;
  logic [IFLAGS_W-1:0] instr_q, instr_d;

  logic       flags_ld;
  logic       zf, cf;
  logic       taken;

  logic       dec_en, mem_rd, mem_wr, addr_sel, ir_ld, pc_inc, pc_ld, reg_we;
  logic [1:0] wb_sel;
  logic [2:0] alu_op;
  logic       in_en, out_en, halted, illegal;

  flag_reg u_flag_reg (
    .clk  (clk),
    .rst  (rst),
    .ld   (flags_ld),
    .z_in (bus.alu_z),
    .c_in (bus.alu_c),
    .zf   (zf),
    .cf   (cf)
  );

  // Branch decision uses the flags as held at EXEC entry; any flag update
  // only lands on the edge that leaves EXEC.
  assign taken = instr_q[IF_JMP] | (instr_q[IF_JZ] & zf) | (instr_q[IF_JC] & cf);

  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    flags_ld = 1'b0;
    dec_en   = 1'b0;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    addr_sel = 1'b0;
    ir_ld    = 1'b0;
    pc_inc   = 1'b0;
    pc_ld    = 1'b0;
    reg_we   = 1'b0;
    wb_sel   = WB_ALU;
    alu_op   = ALU_PASS;
    in_en    = 1'b0;
    out_en   = 1'b0;
    halted   = 1'b0;
    illegal  = 1'b0;

    unique case (state_q)
      ST_FETCH: begin
        // While reset is held the state already reads FETCH; keep the
        // memory strobe quiet until reset is released.
        if (bus.run && !rst) begin
          mem_rd  = 1'b1;
          state_d = ST_LOAD_IR;
        end
      end

      ST_LOAD_IR: begin
        ir_ld   = 1'b1;
        pc_inc  = 1'b1;
        state_d = ST_DECODE;
      end

      ST_DECODE: begin
        dec_en  = 1'b1;
        instr_d = bus.iflags;
        if (is_one_hot(bus.iflags)) begin
          state_d = ST_EXEC;
        end else begin
          illegal = 1'b1;
          state_d = ST_FETCH;
        end
      end

      ST_EXEC: begin
        state_d = ST_FETCH;
        if (instr_q[IF_MOVA]) begin
          reg_we = 1'b1;
        end else if (instr_q[IF_MOVB]) begin
          mem_wr   = 1'b1;
          addr_sel = 1'b1;
        end else if (instr_q[IF_MOVC]) begin
          mem_rd   = 1'b1;
          addr_sel = 1'b1;
          state_d  = ST_MEM;
        end else if (instr_q[IF_ADD]) begin
          reg_we = 1'b1; alu_op = ALU_ADD; flags_ld = 1'b1;
        end else if (instr_q[IF_SUB]) begin
          reg_we = 1'b1; alu_op = ALU_SUB; flags_ld = 1'b1;
        end else if (instr_q[IF_AND1]) begin
          reg_we = 1'b1; alu_op = ALU_AND; flags_ld = 1'b1;
        end else if (instr_q[IF_NOT1]) begin
          reg_we = 1'b1; alu_op = ALU_NOT; flags_ld = 1'b1;
        end else if (instr_q[IF_RSR]) begin
          reg_we = 1'b1; alu_op = ALU_SHR; flags_ld = 1'b1;
        end else if (instr_q[IF_RSL]) begin
          reg_we = 1'b1; alu_op = ALU_SHL; flags_ld = 1'b1;
        end else if (taken) begin
          // Read the target address byte; MEM then loads it into the PC.
          mem_rd  = 1'b1;
          state_d = ST_MEM;
        end else if (instr_q[IF_JZ] || instr_q[IF_JC]) begin
          // Untaken branch: step over the address byte.
          pc_inc = 1'b1;
        end else if (instr_q[IF_IN1]) begin
          in_en  = 1'b1;
          reg_we = 1'b1;
          wb_sel = WB_IN;
        end else if (instr_q[IF_OUT1]) begin
          out_en = 1'b1;
        end else if (instr_q[IF_NOP]) begin
          state_d = ST_FETCH;
        end else if (instr_q[IF_HALT]) begin
          state_d = ST_HALT;
        end
      end

      ST_MEM: begin
        state_d = ST_FETCH;
        if (instr_q[IF_MOVC]) begin
          reg_we = 1'b1;
          wb_sel = WB_MEM;
        end else begin
          pc_ld = 1'b1;
        end
      end

      ST_HALT: begin
        halted = 1'b1;
      end

      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_FETCH;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
    end
  end

  assign bus.dec_en   = dec_en;
  assign bus.mem_rd   = mem_rd;
  assign bus.mem_wr   = mem_wr;
  assign bus.addr_sel = addr_sel;
  assign bus.ir_ld    = ir_ld;
  assign bus.pc_inc   = pc_inc;
  assign bus.pc_ld    = pc_ld;
  assign bus.reg_we   = reg_we;
  assign bus.wb_sel   = wb_sel;
  assign bus.alu_op   = alu_op;
  assign bus.in_en    = in_en;
  assign bus.out_en   = out_en;
  assign bus.halted   = halted;
  assign bus.illegal  = illegal;
  assign bus.state    = state_q;

endmodule

// File: doc/ctrl_sequencer.md
CTRL_SEQUENCER -- requirements
Module: ctrl_sequencer

Interface
REQ-001 The port clk SHALL be an input, 1 bit wide, and serve as the single system clock, rising-edge active.
REQ-002 The port rst SHALL be an input, 1 bit wide, and act as an asynchronous, active-high reset.
REQ-003 The port run SHALL be an input, 1 bit wide; when it is 0, the block stalls in FETCH.
REQ-004 The port iflags SHALL be an input, 16 bits wide, carrying one-hot decoded instruction flags. Bit order from 15 down to 0: mova, movb, movc, add, sub, and1, not1, rsr, rsl, jmp, jz, jc, in1, out1, nop, halt.
REQ-005 The ports alu_z and alu_c SHALL be inputs, 1 bit each, carrying the combinational ALU zero and carry results.
REQ-006 The port dec_en SHALL be an output, 1 bit wide, driving the decoder enable.
REQ-007 The ports mem_rd and mem_wr SHALL be outputs, 1 bit each, acting as memory strobes.
REQ-008 The port addr_sel SHALL be an output, 1 bit wide, selecting the memory address source: 0 selects PC, 1 selects register.
REQ-009 The ports ir_ld, pc_inc and pc_ld SHALL be outputs, 1 bit each, acting as IR/PC load and increment strobes.
REQ-010 The port reg_we SHALL be an output, 1 bit wide, acting as the register-file write enable.
REQ-011 The port wb_sel SHALL be an output, 2 bits wide, selecting write-back: 0 selects ALU, 1 selects MEM, 2 selects IN.
REQ-012 The port alu_op SHALL be an output, 3 bits wide, with codes PASS=0, ADD=1, SUB=2, AND=3, NOT=4, SHR=5, SHL=6.
REQ-013 The ports in_en and out_en SHALL be outputs, 1 bit each, acting as I/O port strobes.
REQ-014 The outputs halted and illegal SHALL each be 1 bit wide: halted is a status level and illegal is a one-cycle pulse.
REQ-015 The output state SHALL be 3 bits wide and present the current FSM state for debug.

Function
REQ-016 The FSM states SHALL be encoded as FETCH=0, LOAD_IR=1, DECODE=2, EXEC=3, MEM=4 and HALT=5.
REQ-017 All strobes SHALL be Moore outputs of state plus latched instruction; every output not named for a state or instruction SHALL be 0, and alu_op SHALL be PASS.
REQ-018 In FETCH: if run=1, assert mem_rd with addr_sel=0 and move to LOAD_IR; otherwise hold in FETCH with no strobes asserted.
REQ-019 In LOAD_IR: assert ir_ld and pc_inc, then move to DECODE.
REQ-020 In DECODE: assert dec_en, register iflags into an internal instruction latch, then move to EXEC; if the sampled iflags is not exactly one-hot, pulse illegal for one cycle and move to FETCH.
REQ-021 EXEC for mova, add, sub, and1, not1, rsr and rsl SHALL assert reg_we with wb_sel=0 and alu_op PASS, ADD, SUB, AND, NOT, SHR or SHL respectively, then move to FETCH.
REQ-022 For add, sub, and1, not1, rsr and rsl, EXEC SHALL latch alu_z/alu_c into internal zf/cf on the clock edge; mova, movb, movc, in1 and out1 SHALL leave zf/cf unchanged.
REQ-023 EXEC for movb SHALL assert mem_wr with addr_sel=1, then move to FETCH.
REQ-024 EXEC for movc SHALL assert mem_rd with addr_sel=1 and move to MEM; MEM then asserts reg_we with wb_sel=1 and moves to FETCH.
REQ-025 EXEC for jmp, for jz with zf=1 and for jc with cf=1 SHALL assert mem_rd with addr_sel=0 and move to MEM; MEM then asserts pc_ld and moves to FETCH.
REQ-026 EXEC for jz with zf=0 or jc with cf=0 SHALL assert pc_inc to skip the address byte, then move to FETCH; the branch decision SHALL use zf/cf as they stand at EXEC entry.
REQ-027 EXEC for in1 SHALL assert in_en and reg_we with wb_sel=2; EXEC for out1 SHALL assert out_en; EXEC for nop asserts nothing; all three then move to FETCH.
REQ-028 EXEC for halt SHALL move to HALT; HALT drives halted=1, asserts no strobes, and is left only by rst.
REQ-029 A run drop outside FETCH SHALL NOT abort the instruction in progress; the stall takes effect at the next FETCH.
REQ-030 Cycle counts SHALL be: 4 cycles for ALU/mov/IO/nop/untaken-branch instructions, and 5 cycles for movc and taken jumps.

Reset
REQ-031 When rst=1 (asynchronous), the block SHALL enter FETCH, clear zf, cf and the instruction latch, and drive every output 0 with alu_op=PASS and state=0.
REQ-032 A reset asserted mid-instruction SHALL abort that instruction with no further strobes; the first fetch SHALL occur in the first cycle with rst=0 and run=1.

Structure
REQ-033 The package ctrl_pkg SHALL hold the state encoding, the alu_op codes, the wb_sel codes and the iflags bit indices.
REQ-034 The block SHALL contain one sub-module, flag_reg, which holds zf/cf with a load enable and an asynchronous clear.

Verification
REQ-035 Verification SHALL cover: reset, then run=1 with iflags=add and alu_z=1 -> mem_rd, ir_ld+pc_inc, dec_en, then reg_we with alu_op=1 over 4 cycles, with zf=1 afterwards.
REQ-036 Verification SHALL cover: zf=1 then jz -> EXEC mem_rd with addr_sel=0, MEM pc_ld=1; zf=0 then jz -> EXEC pc_inc=1, no pc_ld, back in FETCH after 4 cycles.
REQ-037 Verification SHALL cover: movc -> EXEC mem_rd with addr_sel=1, MEM reg_we with wb_sel=1; movb -> mem_wr with addr_sel=1 and no reg_we.
REQ-038 Verification SHALL cover: iflags=0x0000 or 0x8001 in DECODE -> illegal=1 for exactly 1 cycle, no other strobe, state=FETCH next cycle.
REQ-039 Verification SHALL cover: halt -> state=5 and halted=1 held for 20 cycles with run=1; rst pulse -> state=0 and halted=0.
REQ-040 Verification SHALL cover: rst asserted during MEM of jmp -> pc_ld never asserted; run=0 -> state stays 0 with mem_rd=0.
